// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_ctrl
//  Purpose  : Assembles the UART RX byte stream into command frames
//             (HDR, ADDR, LEN, DATA[LEN], optional CSUM). The payload is
//             buffered and validated, then burst-written to the viewer
//             register file.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    sys_clk    in   1  system clock
//    sys_rst    in   1  asynchronous reset, active-high
//    rx_done    in   1  byte-valid level from UART RX (may stay high)
//    rx_data    in   8  received byte, valid while rx_done is high
//    wr_en      out  1  register write request
//    wr_addr    out  8  write address
//    wr_data    out  8  write data
//    wr_ready   in   1  write accepted when wr_en & wr_ready
//    frame_ok   out  1  1-clk pulse: frame fully written
//    frame_err  out  1  1-clk pulse: frame error or overrun
//    err_code   out  2  0 timeout, 1 bad LEN, 2 bad CSUM, 3 overrun
//    busy       out  1  high whenever the FSM is not idle
//  Configuration macro
//    UART_CMD_CSUM_EN : when defined, a checksum byte
//                       (ADDR + LEN + sum(DATA)) mod 256 must follow DATA.
// ============================================================================
module uart_cmd_ctrl #(
    parameter int         MAX_LEN     = 8,
    parameter logic [7:0] HDR_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 270000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
`ifdef UART_CMD_CSUM_EN
    localparam logic [1:0] ERR_CSUM    = 2'd2;
`endif
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
`ifdef UART_CMD_CSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_WRITE = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t           state;
    logic             rx_done_d;
    logic [7:0]       base;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic             burst_done;   // last write accepted, frame_ok due
    logic [7:0]       pay_buf [MAX_LEN];
`ifdef UART_CMD_CSUM_EN
    logic [7:0]       sum;
`endif

    logic             byte_ev;
    logic             in_frame;
    logic             last_idx;
    logic [LEN_W-1:0] idx_nxt;

    // One event per byte regardless of how long rx_done stays high.
    assign byte_ev  = rx_done & ~rx_done_d;
    assign idx_nxt  = idx + LEN_ONE;
    assign last_idx = (idx == (len - LEN_ONE));
    assign busy     = (state != S_IDLE);

`ifdef UART_CMD_CSUM_EN
    assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA) || (state == S_CSUM);
`else
    assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA);
`endif

    // Payload storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge sys_clk) begin
        if (state == S_DATA && byte_ev) begin
            pay_buf[idx[IDX_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            rx_done_d  <= 1'b0;
            base       <= 8'd0;
            len        <= '0;
            idx        <= '0;
            tmo_cnt    <= '0;
            burst_done <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 8'd0;
            wr_data    <= 8'd0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
`ifdef UART_CMD_CSUM_EN
            sum        <= 8'd0;
`endif
        end else begin
            rx_done_d <= rx_done;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            // Inter-byte timeout. A byte in the same clock wins, so the
            // timeout branch only runs when no byte event is present and
            // never collides with the byte handling below.
            if (in_frame) begin
                if (byte_ev) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state     <= S_ERR;
                    frame_err <= 1'b1;
                    err_code  <= ERR_TIMEOUT;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (byte_ev && rx_data == HDR_BYTE) begin
                        state   <= S_ADDR;
                        tmo_cnt <= '0;
                    end
                end

                S_ADDR: begin
                    if (byte_ev) begin
                        base  <= rx_data;
`ifdef UART_CMD_CSUM_EN
                        sum   <= rx_data;
`endif
                        state <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (byte_ev) begin
                        if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                            state     <= S_ERR;
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                        end else begin
                            len   <= rx_data[LEN_W-1:0];
                            idx   <= '0;
`ifdef UART_CMD_CSUM_EN
                            sum   <= sum + rx_data;
`endif
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (byte_ev) begin
`ifdef UART_CMD_CSUM_EN
                        sum <= sum + rx_data;
`endif
                        if (last_idx) begin
                            idx <= '0;
`ifdef UART_CMD_CSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_WRITE;
`endif
                        end else begin
                            idx <= idx_nxt;
                        end
                    end
                end

`ifdef UART_CMD_CSUM_EN
                S_CSUM: begin
                    if (byte_ev) begin
                        if (rx_data == sum) begin
                            state <= S_WRITE;
                        end else begin
                            state     <= S_ERR;
                            frame_err <= 1'b1;
                            err_code  <= ERR_CSUM;
                        end
                    end
                end
`endif

                S_WRITE: begin
                    // Bytes arriving mid-burst are dropped and flagged; the
                    // burst itself is unaffected.
                    if (byte_ev) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_OVERRUN;
                    end
                    if (burst_done) begin
                        burst_done <= 1'b0;
                        frame_ok   <= 1'b1;
                        state      <= S_IDLE;
                    end else if (!wr_en) begin
                        // First request, one clock after entering WRITE.
                        wr_en   <= 1'b1;
                        wr_addr <= base + 8'(idx);
                        wr_data <= pay_buf[idx[IDX_W-1:0]];
                    end else if (wr_ready) begin
                        if (last_idx) begin
                            wr_en      <= 1'b0;
                            burst_done <= 1'b1;
                        end else begin
                            idx     <= idx_nxt;
                            wr_addr <= base + 8'(idx_nxt);
                            wr_data <= pay_buf[idx_nxt[IDX_W-1:0]];
                        end
                    end
                end

                S_ERR: begin
                    // frame_err was raised on entry; any byte here is dropped.
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_ctrl
//  Purpose  : Directed self-checking bench for uart_cmd_ctrl. Inputs are
//             driven 2 time units after each rising clock edge; a monitor
//             samples on the falling edge and logs accepted writes, pulses
//             and held write requests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int MAX_LEN     = 8;
    localparam int TIMEOUT_CYC = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    uart_cmd_ctrl #(
        .MAX_LEN    (MAX_LEN),
        .HDR_BYTE   (8'hA5),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         ok_cnt    = 0;
    int         err_cnt   = 0;
    int         wren_cnt  = 0;
    int         ok_cyc    = 0;
    int         acc_cyc   = 0;
    logic [1:0] last_code = 2'd0;
    logic [7:0] qa [$];
    logic [7:0] qd [$];
    logic       held_valid = 1'b0;
    logic [7:0] held_a = 8'd0;
    logic [7:0] held_d = 8'd0;

    // Falling-edge monitor: sees exactly what the DUT sees at the next
    // rising edge, since inputs change only just after rising edges.
    always @(negedge clk) begin
        cyc++;
        if (wr_en && wr_ready) begin
            qa.push_back(wr_addr);
            qd.push_back(wr_data);
            acc_cyc = cyc;
        end
        if (frame_ok) begin
            ok_cnt++;
            ok_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            last_code = err_code;
        end
        if (wr_en) wren_cnt++;
        if (held_valid && wr_en) begin
            checks++;
            assert (wr_addr === held_a && wr_data === held_d) else begin
                errors++;
                $error("FAIL hold_stable obs=%02h/%02h exp=%02h/%02h",
                       wr_addr, wr_data, held_a, held_d);
            end
        end
        held_valid = wr_en && !wr_ready;
        held_a     = wr_addr;
        held_d     = wr_data;
    end

    int b_w, b_ok, b_err, b_wren;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // Byte held high for 'hold' clocks, then low for one clock.
    task automatic send(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic snap();
        b_w    = qa.size();
        b_ok   = ok_cnt;
        b_err  = err_cnt;
        b_wren = wren_cnt;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
        tick();
        tick();
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        rx_done  = 1'b0;
        rx_data  = 8'd0;
        wr_ready = 1'b0;
        repeat (3) tick();

        // ---------------- reset state ----------------
        chk("rst_wr_en",     {31'd0, wr_en},     32'd0);
        chk("rst_wr_addr",   {24'd0, wr_addr},   32'd0);
        chk("rst_wr_data",   {24'd0, wr_data},   32'd0);
        chk("rst_frame_ok",  {31'd0, frame_ok},  32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_err_code",  {30'd0, err_code},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        rst = 1'b0;
        tick();

        // ---------------- 1: good 2-byte frame ----------------
        wr_ready = 1'b1;
        snap();
        send(8'h5A, 1);              // junk before header is ignored
        send(8'hA5, 1);
        send(8'h10, 1);
        send(8'h02, 1);
        send(8'h11, 1);
        send(8'h22, 1);
`ifdef UART_CMD_CSUM_EN
        send(8'h45, 1);              // 10+02+11+22 = 45
`endif
        wait_idle("t1_idle");
        chk("t1_nwrites", qa.size() - b_w, 2);
        chk("t1_w0_addr", {24'd0, qa[b_w]},   32'h10);
        chk("t1_w0_data", {24'd0, qd[b_w]},   32'h11);
        chk("t1_w1_addr", {24'd0, qa[b_w+1]}, 32'h11);
        chk("t1_w1_data", {24'd0, qd[b_w+1]}, 32'h22);
        chk("t1_ok_cnt",  ok_cnt - b_ok, 1);
        chk("t1_err_cnt", err_cnt - b_err, 0);
        chk("t1_ok_lat",  ok_cyc - acc_cyc, 2);

`ifdef UART_CMD_CSUM_EN
        // ---------------- 2: bad checksum ----------------
        snap();
        send(8'hA5, 1);
        send(8'h10, 1);
        send(8'h02, 1);
        send(8'h11, 1);
        send(8'h22, 1);
        send(8'h00, 1);
        wait_idle("t2_idle");
        chk("t2_no_wren",  wren_cnt - b_wren, 0);
        chk("t2_err_cnt",  err_cnt - b_err, 1);
        chk("t2_err_code", {30'd0, last_code}, 32'd2);
`endif

        // ---------------- 3: bad LEN 0 and MAX_LEN+1 ----------------
        snap();
        send(8'hA5, 1);
        send(8'h10, 1);
        send(8'h00, 1);
        wait_idle("t3a_idle");
        chk("t3a_err_cnt",  err_cnt - b_err, 1);
        chk("t3a_err_code", {30'd0, last_code}, 32'd1);
        snap();
        send(8'hA5, 1);
        send(8'h10, 1);
        send(8'h09, 1);
        wait_idle("t3b_idle");
        chk("t3b_err_cnt",  err_cnt - b_err, 1);
        chk("t3b_err_code", {30'd0, last_code}, 32'd1);
        chk("t3b_no_wren",  wren_cnt - b_wren, 0);
        snap();
        send(8'hA5, 1);
        send(8'h20, 1);
        send(8'h01, 1);
        send(8'h5A, 1);
`ifdef UART_CMD_CSUM_EN
        send(8'h7B, 1);              // 20+01+5A = 7B
`endif
        wait_idle("t3c_idle");
        chk("t3c_nwrites", qa.size() - b_w, 1);
        chk("t3c_w0_addr", {24'd0, qa[b_w]}, 32'h20);
        chk("t3c_w0_data", {24'd0, qd[b_w]}, 32'h5A);
        chk("t3c_ok_cnt",  ok_cnt - b_ok, 1);

        // ---------------- 4: inter-byte timeout ----------------
        // The 0x10 event is sampled at the first edge inside send(); send
        // returns one edge later, so TIMEOUT_CYC-1 further edges remain.
        snap();
        send(8'hA5, 1);
        send(8'h10, 1);
        n = 0;
        while (frame_err !== 1'b1 && n < 3 * TIMEOUT_CYC) begin
            tick();
            n++;
        end
        chk("t4_timeout_clks", n, TIMEOUT_CYC - 1);
        chk("t4_err_code", {30'd0, err_code}, 32'd0);
        wait_idle("t4_idle");
        chk("t4_err_cnt", err_cnt - b_err, 1);

        // ---------------- 5: address wrap, wr_ready toggling ----------------
        snap();
        wr_ready = 1'b1;
        send(8'hA5, 1);
        send(8'hFE, 1);
        send(8'h03, 1);
        send(8'h01, 1);
        send(8'h02, 1);
`ifdef UART_CMD_CSUM_EN
        send(8'h03, 1);
        wr_ready = 1'b0;
        send(8'h07, 1);              // FE+03+01+02+03 = 107 -> 07
`else
        wr_ready = 1'b0;
        send(8'h03, 1);
`endif
        n = 0;
        while (busy === 1'b1 && n < 80) begin
            wr_ready = ~wr_ready;
            tick();
            n++;
        end
        chk("t5_idle", {31'd0, busy}, 32'd0);
        tick();
        tick();
        chk("t5_nwrites", qa.size() - b_w, 3);
        chk("t5_w0_addr", {24'd0, qa[b_w]},   32'hFE);
        chk("t5_w0_data", {24'd0, qd[b_w]},   32'h01);
        chk("t5_w1_addr", {24'd0, qa[b_w+1]}, 32'hFF);
        chk("t5_w1_data", {24'd0, qd[b_w+1]}, 32'h02);
        chk("t5_w2_addr", {24'd0, qa[b_w+2]}, 32'h00);
        chk("t5_w2_data", {24'd0, qd[b_w+2]}, 32'h03);
        chk("t5_ok_cnt",  ok_cnt - b_ok, 1);
        chk("t5_ok_lat",  ok_cyc - acc_cyc, 2);

        // ---------------- 6: long rx_done, overrun in WRITE ----------------
        snap();
        wr_ready = 1'b1;
        send(8'hA5, 50);
        send(8'h30, 50);
        send(8'h02, 50);
        send(8'hAB, 50);
`ifdef UART_CMD_CSUM_EN
        send(8'hCD, 50);
        wr_ready = 1'b0;
        send(8'hAA, 50);             // 30+02+AB+CD = 1AA -> AA
`else
        wr_ready = 1'b0;
        send(8'hCD, 50);
`endif
        chk("t6_busy_stall", {31'd0, busy}, 32'd1);
        send(8'h77, 1);              // arrives while the burst is stalled
        wr_ready = 1'b1;
        wait_idle("t6_idle");
        chk("t6_err_cnt",  err_cnt - b_err, 1);
        chk("t6_err_code", {30'd0, last_code}, 32'd3);
        chk("t6_nwrites",  qa.size() - b_w, 2);
        chk("t6_w0_addr",  {24'd0, qa[b_w]},   32'h30);
        chk("t6_w0_data",  {24'd0, qd[b_w]},   32'hAB);
        chk("t6_w1_addr",  {24'd0, qa[b_w+1]}, 32'h31);
        chk("t6_w1_data",  {24'd0, qd[b_w+1]}, 32'hCD);
        chk("t6_ok_cnt",   ok_cnt - b_ok, 1);

        // ---------------- 7: reset in the middle of a burst ----------------
        wr_ready = 1'b0;
        send(8'hA5, 1);
        send(8'h40, 1);
        send(8'h01, 1);
        send(8'h99, 1);
`ifdef UART_CMD_CSUM_EN
        send(8'hDA, 1);              // 40+01+99 = DA
`endif
        chk("t7_wren_pre", {31'd0, wr_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t7_rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("t7_rst_busy",  {31'd0, busy},  32'd0);
        tick();
        rst      = 1'b0;
        wr_ready = 1'b1;
        snap();
        repeat (5) tick();
        chk("t7_write_lost", wren_cnt - b_wren, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
